// File: rtl/onehot_pos_serializer.sv
// Bit-mask to bit-position serializer.
// Accepts a Width-bit mask and emits the index of every set bit, lowest first,
// one index per pos_valid_o/pos_ready_i handshake.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   flush_i               synchronous abort of the mask in flight
//   mask_valid_i/_ready_o mask input handshake, mask_i payload
//   pos_valid_o/_ready_i  position output handshake
//   pos_o                 index of lowest remaining set bit
//   pos_last_o            pos_o is the final set bit of the mask
//   beat_idx_o            0-based ordinal of pos_o within the mask
//   busy_o                a mask is being scanned
module onehot_pos_serializer #(
    parameter int unsigned  Width    = 32,
    localparam int unsigned PosWidth = $clog2(Width)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                mask_valid_i,
    output logic                mask_ready_o,
    input  logic [Width-1:0]    mask_i,
    output logic                pos_valid_o,
    input  logic                pos_ready_i,
    output logic [PosWidth-1:0] pos_o,
    output logic                pos_last_o,
    output logic [PosWidth:0]   beat_idx_o,
    output logic                busy_o
);

    localparam int unsigned BeatW = PosWidth + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [Width-1:0]   mask_q, mask_d;
    logic [BeatW-1:0]   beat_q, beat_d;
    logic               one_left;

    // Index of the lowest set bit; 0 for an empty mask.
    function automatic logic [PosWidth-1:0] lowest_set(input logic [Width-1:0] m);
        logic [PosWidth-1:0] idx;
        idx = '0;
        for (int i = int'(Width) - 1; i >= 0; i--) begin
            if (m[i]) idx = PosWidth'(i);
        end
        return idx;
    endfunction

    // Exactly one bit left: clearing the lowest set bit leaves nothing.
    assign one_left = (mask_q != '0) && ((mask_q & (mask_q - Width'(1))) == '0);

    // Outputs depend only on registered state, except flush_i gating acceptance.
    assign mask_ready_o = (state_q == IDLE) && !flush_i;
    assign pos_valid_o  = (state_q == SCAN);
    assign busy_o       = (state_q == SCAN);
    assign pos_o        = lowest_set(mask_q);
    assign pos_last_o   = (state_q == SCAN) && one_left;
    assign beat_idx_o   = beat_q;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            mask_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                // An all-zero mask is consumed without leaving IDLE.
                if (mask_valid_i && mask_ready_o && (mask_i != '0)) begin
                    mask_d  = mask_i;
                    beat_d  = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (flush_i) begin
                    mask_d  = '0;
                    beat_d  = '0;
                    state_d = IDLE;
                end else if (pos_ready_i) begin
                    mask_d = mask_q & (mask_q - Width'(1));
                    if (one_left) begin
                        // Counter returns to 0 so beat_idx_o reads 0 while idle.
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BeatW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                mask_d  = '0;
                beat_d  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_onehot_pos_serializer.sv
// Testbench for onehot_pos_serializer: table-driven masks, directed corner
// sequences and random traffic, all compared against a queue-based model.
module tb_onehot_pos_serializer;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        mask_valid;
    logic        mask_ready;
    logic [31:0] mask;
    logic        pos_valid;
    logic        pos_ready;
    logic [4:0]  pos;
    logic        pos_last;
    logic [5:0]  beat_idx;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Model: positions still to be delivered for the current mask.
    int q[$];
    int delivered = 0;
    // Positions observed on DUT handshakes.
    int obs[$];

    onehot_pos_serializer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .mask_valid_i (mask_valid),
        .mask_ready_o (mask_ready),
        .mask_i       (mask),
        .pos_valid_o  (pos_valid),
        .pos_ready_i  (pos_ready),
        .pos_o        (pos),
        .pos_last_o   (pos_last),
        .beat_idx_o   (beat_idx),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] m;
        int          cnt;
        int          first;
        int          last;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        delivered = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, compare, then
    // advance the model across the rising edge.
    task automatic cyc(input logic fl, input logic mv, input logic [31:0] m, input logic pr);
        bit ev;
        @(negedge clk);
        flush      = fl;
        mask_valid = mv;
        mask       = m;
        pos_ready  = pr;
        #1;
        ev = (q.size() != 0);
        chk("pos_valid",  32'(pos_valid),  32'(ev));
        chk("busy",       32'(busy),       32'(ev));
        chk("mask_ready", 32'(mask_ready), 32'(!ev && !fl));
        chk("pos",        32'(pos),        ev ? 32'(q[0]) : 32'd0);
        chk("pos_last",   32'(pos_last),   32'(ev && q.size() == 1));
        chk("beat_idx",   32'(beat_idx),   ev ? 32'(delivered) : 32'd0);
        if (pos_valid && pr) obs.push_back(int'(pos));
        @(posedge clk);
        if (ev) begin
            if (fl) begin
                model_reset();
            end else if (pr) begin
                void'(q.pop_front());
                delivered++;
                if (q.size() == 0) delivered = 0;
            end
        end else if (!fl && mv && m != 32'd0) begin
            delivered = 0;
            for (int i = 0; i < 32; i++) if (m[i]) q.push_back(i);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mask_ready"}, 32'(mask_ready), 32'd1);
        chk({tag, "_pos_valid"},  32'(pos_valid),  32'd0);
        chk({tag, "_pos"},        32'(pos),        32'd0);
        chk({tag, "_pos_last"},   32'(pos_last),   32'd0);
        chk({tag, "_beat_idx"},   32'(beat_idx),   32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
    endtask

    // Let the current mask drain with pos_ready high; bounded.
    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            cyc(1'b0, 1'b0, 32'd0, 1'b1);
            n++;
        end
        chk({name, "_drain_timeout"}, 32'(q.size()), 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h0000aaee, 10, 1, 15};
        vecs[1] = '{32'h00000020, 1, 5, 5};
        vecs[2] = '{32'h00001000, 1, 12, 12};
        vecs[3] = '{32'h80000001, 2, 0, 31};
        vecs[4] = '{32'h00000000, 0, 0, 0};
        vecs[5] = '{32'hffffffff, 32, 0, 31};
        vecs[6] = '{32'h00000100, 1, 8, 8};
        vecs[7] = '{32'h0000f000, 4, 12, 15};

        rst_n = 1'b0; flush = 1'b0; mask_valid = 1'b0; mask = '0; pos_ready = 1'b0;
        #12;
        chk_reset_outputs("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cyc(1'b0, 1'b0, 32'd0, 1'b1);

        // Table: full masks with pos_ready held high.
        for (int v = 0; v < 8; v++) begin
            obs.delete();
            cyc(1'b0, 1'b1, vecs[v].m, 1'b1);
            drain("table");
            chk("table_count", 32'(obs.size()), 32'(vecs[v].cnt));
            if (vecs[v].cnt > 0 && obs.size() > 0) begin
                chk("table_first", 32'(obs[0]), 32'(vecs[v].first));
                chk("table_last",  32'(obs[obs.size()-1]), 32'(vecs[v].last));
            end
            cyc(1'b0, 1'b0, 32'd0, 1'b1);
        end

        // Backpressure: 0 held while stalled, then 31 last.
        obs.delete();
        cyc(1'b0, 1'b1, 32'h80000001, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        chk("stall_count", 32'(obs.size()), 32'd2);
        if (obs.size() == 2) chk("stall_second", 32'(obs[1]), 32'd31);

        // Asynchronous reset mid-scan after four beats.
        cyc(1'b0, 1'b1, 32'hffffffff, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        #2;
        chk("pre_reset_pos", 32'(pos), 32'd4);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        obs.delete();
        cyc(1'b0, 1'b1, 32'h00000100, 1'b1);
        drain("post_reset");
        chk("post_reset_count", 32'(obs.size()), 32'd1);
        if (obs.size() == 1) chk("post_reset_pos", 32'(obs[0]), 32'd8);

        // Flush while stalled on pos 13.
        cyc(1'b0, 1'b1, 32'h0000f000, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        chk("flush_beat_idx", 32'(beat_idx), 32'd0);
        // Flush in IDLE blocks acceptance.
        cyc(1'b1, 1'b1, 32'h00000004, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        obs.delete();
        cyc(1'b0, 1'b1, 32'h00000006, 1'b1);
        drain("after_flush");
        chk("after_flush_count", 32'(obs.size()), 32'd2);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(15) == 0), 1'($urandom_range(1)),
                $urandom & $urandom & $urandom, 1'($urandom_range(1)));
        end
        drain("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
